// File: rtl/match_tracker.sv
// rtl/match_tracker.sv - turns each high run of ans into a counted, measured event
// Counts runs, tracks the longest run and offers each run length on a one-entry valid/ready register.
module match_tracker #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ans,
  input  logic             clr,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] run_cnt,
  output logic [LEN_W-1:0] max_len,
  output logic             out_valid,
  output logic [LEN_W-1:0] out_len,
  output logic             overflow
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic [CNT_W-1:0] run_cnt_d;
  logic [LEN_W-1:0] max_len_d, out_len_d;
  logic             out_valid_d, overflow_d;

  assign busy = (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    cur_len_d   = cur_len_q;
    run_cnt_d   = run_cnt;
    max_len_d   = max_len;
    out_len_d   = out_len;
    out_valid_d = out_valid;
    overflow_d  = overflow;
    if (clr) begin
      state_d     = IDLE;
      cur_len_d   = '0;
      run_cnt_d   = '0;
      max_len_d   = '0;
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      // A pop frees the register; a push in the same cycle refills it below.
      if (out_valid && out_ready) out_valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (ans) begin
            state_d   = RUN;
            cur_len_d = LEN_W'(1);
            if (run_cnt != '1) run_cnt_d = run_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (ans) begin
            if (cur_len_q != '1) cur_len_d = cur_len_q + LEN_W'(1);
          end else begin
            state_d   = IDLE;
            cur_len_d = '0;
            if (cur_len_q > max_len) max_len_d = cur_len_q;
            if (!out_valid || out_ready) begin
              out_len_d   = cur_len_q;
              out_valid_d = 1'b1;
            end else begin
              overflow_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_len_q <= '0;
      run_cnt   <= '0;
      max_len   <= '0;
      out_len   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_len_q <= cur_len_d;
      run_cnt   <= run_cnt_d;
      max_len   <= max_len_d;
      out_len   <= out_len_d;
      out_valid <= out_valid_d;
      overflow  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_match_tracker.sv
// tb/tb_match_tracker.sv - randomized and directed bench for match_tracker
// Two instances: default widths and a narrow one for saturation.
module tb_match_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       ans0 = 0, clr0 = 0, rdy0 = 0;
  logic       busy0, out_valid0, overflow0;
  logic [7:0] run_cnt0, max_len0, out_len0;

  logic       ans1 = 0, clr1 = 0, rdy1 = 0;
  logic       busy1, out_valid1, overflow1;
  logic [1:0] run_cnt1;
  logic [3:0] max_len1, out_len1;

  int n_checks = 0;
  int n_fail = 0;

  match_tracker #(.CNT_W(8), .LEN_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .ans(ans0), .clr(clr0), .out_ready(rdy0),
    .busy(busy0), .run_cnt(run_cnt0), .max_len(max_len0),
    .out_valid(out_valid0), .out_len(out_len0), .overflow(overflow0)
  );

  match_tracker #(.CNT_W(2), .LEN_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .ans(ans1), .clr(clr1), .out_ready(rdy1),
    .busy(busy1), .run_cnt(run_cnt1), .max_len(max_len1),
    .out_valid(out_valid1), .out_len(out_len1), .overflow(overflow1)
  );

  // Reference model: unbounded run bookkeeping, clamped to the field width on compare.
  int m_cur[2], m_runs[2], m_mx[2], m_olen[2];
  bit m_run[2], m_valid[2], m_ov[2];
  int lmax[2] = '{255, 15};
  int cmax[2] = '{255, 3};

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_cur[i] = 0; m_runs[i] = 0; m_mx[i] = 0; m_olen[i] = 0;
      m_run[i] = 0; m_valid[i] = 0; m_ov[i] = 0;
    end
  endtask

  task automatic step_model(input int i, input bit a, input bit c, input bit r);
    if (c) begin
      m_run[i] = 0; m_cur[i] = 0; m_runs[i] = 0; m_mx[i] = 0;
      m_valid[i] = 0; m_ov[i] = 0;
    end else begin
      if (m_run[i] && !a) begin
        if (m_cur[i] > m_mx[i]) m_mx[i] = m_cur[i];
        if (!m_valid[i] || r) begin
          m_olen[i] = m_cur[i];
          m_valid[i] = 1;
        end else begin
          m_ov[i] = 1;
        end
      end else if (m_valid[i] && r) begin
        m_valid[i] = 0;
      end
      if (a) begin
        if (!m_run[i]) m_runs[i]++;
        m_cur[i] = m_run[i] ? m_cur[i] + 1 : 1;
        m_run[i] = 1;
      end else begin
        m_run[i] = 0;
        m_cur[i] = 0;
      end
    end
  endtask

  task automatic tick(input bit a0, input bit c0, input bit r0,
                      input bit a1, input bit c1, input bit r1);
    @(negedge clk);
    ans0 = a0; clr0 = c0; rdy0 = r0;
    ans1 = a1; clr1 = c1; rdy1 = r1;
    @(posedge clk);
    step_model(0, a0, c0, r0);
    step_model(1, a1, c1, r1);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({busy0, out_valid0, overflow0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy0, out_valid0, overflow0}); end
    n_checks++; if ({run_cnt0, max_len0} !== 16'd0) begin n_fail++; $display("FAIL reset_stats: got %h want 0", {run_cnt0, max_len0}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 0, 0, 1, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    n_checks++; if ({busy0, out_valid0} !== 2'b11) begin n_fail++; $display("FAIL reset_pre: got %b want 11", {busy0, out_valid0}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b want 0", busy0); end
    n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", out_valid0); end
    n_checks++; if (run_cnt0 !== 8'd0) begin n_fail++; $display("FAIL async_cnt: got %0d want 0", run_cnt0); end
    n_checks++; if (max_len0 !== 8'd0) begin n_fail++; $display("FAIL async_max: got %0d want 0", max_len0); end
    n_checks++; if (out_len0 !== 8'd0) begin n_fail++; $display("FAIL async_len: got %0d want 0", out_len0); end
    n_checks++; if (overflow0 !== 1'b0) begin n_fail++; $display("FAIL async_ovf: got %b want 0", overflow0); end
    n_checks++; if ({busy1, out_valid1} !== 2'b00) begin n_fail++; $display("FAIL async_small: got %b want 00", {busy1, out_valid1}); end
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_chain();
    tick(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick(1, 0, 1, 0, 0, 0);
    n_checks++; if ({busy0, out_valid0} !== 2'b10) begin n_fail++; $display("FAIL chain_busy: got %b want 10", {busy0, out_valid0}); end
    tick(0, 0, 1, 0, 0, 0);
    n_checks++; if (out_valid0 !== 1'b1 || out_len0 !== 8'd3) begin n_fail++; $display("FAIL chain_out: got v=%b len=%0d want v=1 len=3", out_valid0, out_len0); end
    n_checks++; if (run_cnt0 !== 8'd1 || max_len0 !== 8'd3 || busy0 !== 1'b0) begin n_fail++; $display("FAIL chain_stats: got cnt=%0d max=%0d busy=%b want 1 3 0", run_cnt0, max_len0, busy0); end
    tick(0, 0, 1, 0, 0, 0);
    n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL chain_pulse: got %b want 0", out_valid0); end
  endtask

  task automatic test_backpressure();
    bit pat[9] = '{1, 1, 0, 1, 1, 1, 1, 0, 0};
    tick(0, 1, 0, 0, 0, 0);
    foreach (pat[k]) tick(pat[k], 0, 0, 0, 0, 0);
    n_checks++; if (out_valid0 !== 1'b1 || out_len0 !== 8'd2) begin n_fail++; $display("FAIL bp_len: got v=%b len=%0d want v=1 len=2", out_valid0, out_len0); end
    n_checks++; if (overflow0 !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b want 1", overflow0); end
    n_checks++; if (max_len0 !== 8'd4 || run_cnt0 !== 8'd2) begin n_fail++; $display("FAIL bp_stats: got max=%0d cnt=%0d want 4 2", max_len0, run_cnt0); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    tick(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      tick(1, 0, 0, 0, 0, 0);
      if (out_len0 !== 8'd5 || out_valid0 !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_len: got %0d unstable cycles want 0", bad); end
    tick(0, 0, 1, 0, 0, 0);
    n_checks++; if (out_valid0 !== 1'b1 || out_len0 !== 8'd7) begin n_fail++; $display("FAIL poppush_len: got v=%b len=%0d want v=1 len=7", out_valid0, out_len0); end
    n_checks++; if (overflow0 !== 1'b0) begin n_fail++; $display("FAIL poppush_ovf: got %b want 0", overflow0); end
  endtask

  task automatic test_saturation();
    tick(0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 20; k++) tick(0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    n_checks++; if (out_valid1 !== 1'b1 || out_len1 !== 4'd15) begin n_fail++; $display("FAIL sat_len: got v=%b len=%0d want v=1 len=15", out_valid1, out_len1); end
    n_checks++; if (max_len1 !== 4'd15) begin n_fail++; $display("FAIL sat_max: got %0d want 15", max_len1); end
    tick(0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 5; k++) begin
      tick(0, 0, 0, 1, 0, 1);
      tick(0, 0, 0, 0, 0, 1);
    end
    n_checks++; if (run_cnt1 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt: got %0d want 3", run_cnt1); end
  endtask

  task automatic test_clr_mid_run();
    tick(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick(1, 0, 1, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0);
    n_checks++; if ({busy0, out_valid0, overflow0} !== 3'b000) begin n_fail++; $display("FAIL clr_flags: got %b want 000", {busy0, out_valid0, overflow0}); end
    n_checks++; if ({run_cnt0, max_len0} !== 16'd0) begin n_fail++; $display("FAIL clr_stats: got %h want 0", {run_cnt0, max_len0}); end
    tick(1, 0, 1, 0, 0, 0);
    n_checks++; if (busy0 !== 1'b1 || run_cnt0 !== 8'd1) begin n_fail++; $display("FAIL clr_restart: got busy=%b cnt=%0d want 1 1", busy0, run_cnt0); end
  endtask

  task automatic test_random();
    bit a0, a1, c0, c1, r0, r1;
    for (int n = 0; n < 600; n++) begin
      a0 = ($urandom_range(0, 99) < 70);
      a1 = ($urandom_range(0, 99) < 85);
      c0 = ($urandom_range(0, 199) == 0);
      c1 = ($urandom_range(0, 199) == 0);
      r0 = ($urandom_range(0, 99) < 40);
      r1 = ($urandom_range(0, 99) < 60);
      tick(a0, c0, r0, a1, c1, r1);
      n_checks++; if (busy0 !== m_run[0] || out_valid0 !== m_valid[0] || overflow0 !== m_ov[0]) begin n_fail++; $display("FAIL rnd0_flags @%0d: got %b%b%b want %b%b%b", n, busy0, out_valid0, overflow0, m_run[0], m_valid[0], m_ov[0]); end
      n_checks++; if (run_cnt0 !== 8'(sat(m_runs[0], cmax[0])) || max_len0 !== 8'(sat(m_mx[0], lmax[0]))) begin n_fail++; $display("FAIL rnd0_stats @%0d: got cnt=%0d max=%0d want %0d %0d", n, run_cnt0, max_len0, sat(m_runs[0], cmax[0]), sat(m_mx[0], lmax[0])); end
      if (m_valid[0]) begin
        n_checks++; if (out_len0 !== 8'(sat(m_olen[0], lmax[0]))) begin n_fail++; $display("FAIL rnd0_len @%0d: got %0d want %0d", n, out_len0, sat(m_olen[0], lmax[0])); end
      end
      n_checks++; if (busy1 !== m_run[1] || out_valid1 !== m_valid[1] || overflow1 !== m_ov[1]) begin n_fail++; $display("FAIL rnd1_flags @%0d: got %b%b%b want %b%b%b", n, busy1, out_valid1, overflow1, m_run[1], m_valid[1], m_ov[1]); end
      n_checks++; if (run_cnt1 !== 2'(sat(m_runs[1], cmax[1])) || max_len1 !== 4'(sat(m_mx[1], lmax[1]))) begin n_fail++; $display("FAIL rnd1_stats @%0d: got cnt=%0d max=%0d want %0d %0d", n, run_cnt1, max_len1, sat(m_runs[1], cmax[1]), sat(m_mx[1], lmax[1])); end
      if (m_valid[1]) begin
        n_checks++; if (out_len1 !== 4'(sat(m_olen[1], lmax[1]))) begin n_fail++; $display("FAIL rnd1_len @%0d: got %0d want %0d", n, out_len1, sat(m_olen[1], lmax[1])); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_chain();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_clr_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
